// File: rtl/decoder_xx6812.sv
// xx6812 one-wire receiver: classifies high-pulse widths into bits, packs them
// MSB-first into LED words and detects the latch gap that ends a frame.
module decoder_xx6812 #(
    parameter int BITS_PER_LED     = 24,
    parameter int MIN_HIGH_CYCLES  = 2,
    parameter int THRESHOLD_CYCLES = 7,
    parameter int MAX_HIGH_CYCLES  = 18,
    parameter int LATCH_CYCLES     = 600
) (
    input  logic                    clock_12mhz,
    input  logic                    reset,
    input  logic                    serial_data_in,
    output logic [BITS_PER_LED-1:0] parallel_data_out,
    output logic                    data_valid,
    output logic [7:0]              led_index,
    output logic                    frame_end,
    output logic                    error
);
    // state      | meaning
    // WAIT_LATCH | out of sync; ignore the line until a full latch gap
    // IDLE       | line low between bits; watches for rise or latch gap
    // HIGH       | measuring a high pulse
    typedef enum logic [1:0] {WAIT_LATCH, IDLE, HIGH} state_t;

    localparam int HW = $clog2(MAX_HIGH_CYCLES + 2);
    localparam int LW = $clog2(LATCH_CYCLES + 1);
    localparam int BW = $clog2(BITS_PER_LED + 1);

    localparam logic [HW-1:0] HIGH_MIN = HW'(MIN_HIGH_CYCLES);
    localparam logic [HW-1:0] HIGH_THR = HW'(THRESHOLD_CYCLES);
    localparam logic [HW-1:0] HIGH_MAX = HW'(MAX_HIGH_CYCLES);
    localparam logic [HW-1:0] HIGH_SAT = HW'(MAX_HIGH_CYCLES + 1);
    localparam logic [LW-1:0] LOW_LATCH    = LW'(LATCH_CYCLES);
    localparam logic [LW-1:0] LOW_LATCH_M1 = LW'(LATCH_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT     = BW'(BITS_PER_LED - 1);

    state_t                  state;
    logic                    s1, s2, s_prev;
    logic                    rise, fall, bit_val, latch_hit;
    logic [HW-1:0]           high_cnt;
    logic [LW-1:0]           low_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [7:0]              word_cnt;
    logic [BITS_PER_LED-2:0] shift;

    assign rise    = s2 & ~s_prev;
    assign fall    = ~s2 & s_prev;
    assign bit_val = (high_cnt > HIGH_THR);
    // Fires only on the cycle low_cnt steps onto LATCH_CYCLES, so once per gap.
    assign latch_hit = ~s2 && (low_cnt == LOW_LATCH_M1);

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s_prev   <= 1'b0;
            high_cnt <= '0;
            low_cnt  <= '0;
        end else begin
            s1     <= serial_data_in;
            s2     <= s1;
            s_prev <= s2;
            if (rise)
                high_cnt <= HW'(1);
            else if (s2 && (high_cnt < HIGH_SAT))
                high_cnt <= high_cnt + HW'(1);
            if (s2)
                low_cnt <= '0;
            else if (low_cnt < LOW_LATCH)
                low_cnt <= low_cnt + LW'(1);
        end
    end

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            state             <= WAIT_LATCH;
            parallel_data_out <= '0;
            data_valid        <= 1'b0;
            led_index         <= '0;
            frame_end         <= 1'b0;
            error             <= 1'b0;
            bit_cnt           <= '0;
            word_cnt          <= '0;
            shift             <= '0;
        end else begin
            data_valid <= 1'b0;
            frame_end  <= 1'b0;
            error      <= 1'b0;
            case (state)
                WAIT_LATCH: begin
                    if (low_cnt == LOW_LATCH) begin
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        shift    <= '0;
                    end
                end
                IDLE: begin
                    if (rise) begin
                        state <= HIGH;
                    end else if (latch_hit) begin
                        if ((word_cnt != 8'd0) || (bit_cnt != '0))
                            frame_end <= 1'b1;
                        if (bit_cnt != '0)
                            error <= 1'b1;
                        word_cnt <= '0;
                        bit_cnt  <= '0;
                        shift    <= '0;
                    end
                end
                HIGH: begin
                    if (high_cnt > HIGH_MAX) begin
                        // Stream is out of sync: drop everything and resync on a gap.
                        error    <= 1'b1;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        shift    <= '0;
                        state    <= WAIT_LATCH;
                    end else if (fall) begin
                        state <= IDLE;
                        if (high_cnt >= HIGH_MIN) begin
                            if (bit_cnt == LAST_BIT) begin
                                parallel_data_out <= {shift, bit_val};
                                data_valid        <= 1'b1;
                                led_index         <= word_cnt;
                                if (word_cnt != 8'hFF)
                                    word_cnt <= word_cnt + 8'd1;
                                bit_cnt <= '0;
                                shift   <= '0;
                            end else begin
                                shift   <= {shift[BITS_PER_LED-3:0], bit_val};
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                    end
                end
                default: state <= WAIT_LATCH;
            endcase
        end
    end
endmodule
